// File: rtl/weight_loader_if.sv
// Handshake and array-edge bundle between the weight loader and its neighbours.
// The loader takes the slave view; the upstream source / controller / bench takes the master view.
interface weight_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 2,
    parameter int COLS       = 2
);
    logic [COLS*DATA_WIDTH-1:0] s_wdata;
    logic                       s_wvalid;
    logic                       s_wready;
    logic                       swap_req;
    logic                       swap_ack;
    logic [COLS*DATA_WIDTH-1:0] wl_weight_out;
    logic [ROWS-1:0]            wl_accept_w_out;
    logic [ROWS-1:0]            wl_switch_out;
    logic                       tile_loaded;

    modport master (
        output s_wdata, s_wvalid, swap_req,
        input  s_wready, swap_ack, wl_weight_out, wl_accept_w_out, wl_switch_out, tile_loaded
    );

    modport slave (
        input  s_wdata, s_wvalid, swap_req,
        output s_wready, swap_ack, wl_weight_out, wl_accept_w_out, wl_switch_out, tile_loaded
    );
endinterface

// File: rtl/weight_loader.sv
// Edge driver for the PE systolic array: buffers a weight tile, bursts it into the inactive
// registers, then drives the west-edge switch. Define WL_SWITCH_SKEW_EN for a row-skewed switch.
module weight_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 2,
    parameter int COLS       = 2
) (
    input logic            clk,
    input logic            rst,
    weight_loader_if.slave wl
);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ROW_W = COLS * DATA_WIDTH;

    typedef enum logic [1:0] {EMPTY, BURST, LOADED, SWAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] burst_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [ROW_W-1:0] tile_buf [ROWS];
    logic [ROW_W-1:0] sel_row;
    logic [ROW_W-1:0] weight_q;
    logic [ROWS-1:0]  accept_q;
    logic [ROWS-1:0]  switch_q;
    logic             buf_full;
    logic             beat_accept;

    assign buf_full    = (count == CNT_W'(ROWS));
    assign beat_accept = wl.s_wvalid && !buf_full;

    // Rows leave bottom-first so that after the last burst edge PE row r holds tile row r.
    always_comb begin
        sel_idx = (state == BURST) ? burst_idx - 1'b1 : IDX_W'(ROWS - 1);
        sel_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (sel_idx == IDX_W'(r)) sel_row = tile_buf[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            count     <= '0;
            burst_idx <= '0;
            weight_q  <= '0;
            accept_q  <= '0;
            switch_q  <= '0;
            for (int r = 0; r < ROWS; r++) tile_buf[r] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (beat_accept && count == CNT_W'(r)) tile_buf[r] <= wl.s_wdata;
            end
            if (beat_accept) count <= count + 1'b1;

            case (state)
                EMPTY: begin
                    if (buf_full) begin
                        state     <= BURST;
                        burst_idx <= IDX_W'(ROWS - 1);
                        weight_q  <= sel_row;
                        accept_q  <= '1;
                    end
                end
                BURST: begin
                    // The buffer is full throughout BURST, so clearing count never races a new beat.
                    if (burst_idx == '0) begin
                        state    <= LOADED;
                        weight_q <= '0;
                        accept_q <= '0;
                        count    <= '0;
                    end else begin
                        burst_idx <= burst_idx - 1'b1;
                        weight_q  <= sel_row;
                    end
                end
                LOADED: begin
                    if (wl.swap_req) begin
                        state <= SWAP;
`ifdef WL_SWITCH_SKEW_EN
                        switch_q <= ROWS'(1);
`else
                        switch_q <= '1;
`endif
                    end
                end
                SWAP: begin
`ifdef WL_SWITCH_SKEW_EN
                    if (switch_q[ROWS-1]) begin
                        switch_q <= '0;
                        state    <= EMPTY;
                    end else begin
                        switch_q <= switch_q << 1;
                    end
`else
                    switch_q <= '0;
                    state    <= EMPTY;
`endif
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign wl.s_wready        = !buf_full;
    assign wl.swap_ack        = (state == LOADED) && wl.swap_req;
    assign wl.tile_loaded     = (state == LOADED);
    assign wl.wl_weight_out   = weight_q;
    assign wl.wl_accept_w_out = accept_q;
    assign wl.wl_switch_out   = switch_q;
endmodule
